decoder_scan_driver: RTL and testbench
======================================

Name: decoder_scan_driver

Overview:
- Upstream sequencer for the 3-to-8 active-low decoder stage that drives the display/LED select lines.
- Generates the decoder address (A0..A2) and enable (EN), stepping through positions 0..LAST_STEP.
- Each position gets a programmable blanking gap followed by a dwell time. Runs continuously or as a single sweep.
- Lets the decoder scan multiplexed digits without ghosting.

Parameters:
- DWELL_CYCLES, 50000, clock cycles EN is held high per step (>=1).
- BLANK_CYCLES, 2, clock cycles EN is held low before each step's dwell (0 = no gap).
- LAST_STEP, 5, final step index before wrap (0..7); default covers six digit selects.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- RUN  input  1  level; 1 = scanning permitted, 0 = force idle.
- MODE  input  1  0 = continuous scan, 1 = single sweep.
- START  input  1  single-cycle pulse; begins a sweep when MODE=1.
- EN  output  1  decoder enable, active high.
- A0  output  1  decoder address bit 0 (LSB).
- A1  output  1  decoder address bit 1.
- A2  output  1  decoder address bit 2 (MSB).
- SYNC  output  1  one-cycle pulse on the first cycle of step 0.
- BUSY  output  1  high while not IDLE.
- DONE  output  1  one-cycle pulse at the end of a single sweep.

Behaviour:
- All outputs are registered. Reset (async, RST_N=0): state IDLE, step=0, counter=0, EN=0, {A2,A1,A0}=000, SYNC=0, BUSY=0, DONE=0. Outputs take reset values immediately, with no clock needed.
- Address mapping: the decoder asserts DATA[k] low when {A2,A1,A0} = 7-k. The driver therefore outputs {A2,A1,A0} = bitwise inverse of step, so step k selects DATA[k].
- States: IDLE, BLANK, ACTIVE.
- IDLE: EN=0, A=000, BUSY=0.
  - Leaves IDLE at the clock edge where RUN=1 and either MODE=0, or MODE=1 with START=1.
  - On leaving: step=0, SYNC=1 for that first cycle, BUSY=1.
  - Next state is BLANK if BLANK_CYCLES>0, else ACTIVE.
- BLANK: EN=0, A=~step, for exactly BLANK_CYCLES cycles, then ACTIVE.
- ACTIVE: EN=1, A=~step, for exactly DWELL_CYCLES cycles. On the final cycle:
  - step<LAST_STEP: step+1, go to BLANK (or ACTIVE if BLANK_CYCLES=0).
  - step==LAST_STEP and MODE=0: wrap step to 0, pulse SYNC on the first cycle of the new step.
  - step==LAST_STEP and MODE=1: go to IDLE, DONE=1 for one cycle (the first IDLE cycle), EN=0.
- MODE is sampled only at IDLE exit and at the end of the last step; changes mid-sweep take effect at the next wrap point.
- START is ignored when BUSY=1 or RUN=0. No queuing.
- RUN=0 in any state: next edge goes to IDLE, EN=0, A=000, step=0, no DONE pulse.
- RUN and START high on the same edge as the end of the last step in single mode: DONE is pulsed, the state goes to IDLE, and the START is ignored.
- Scan period: (LAST_STEP+1)*(BLANK_CYCLES+DWELL_CYCLES) cycles.
- Internal counter must be wide enough for max(DWELL_CYCLES, BLANK_CYCLES). Wrap of the counter is never visible.

Test Plan:
Use DWELL_CYCLES=4, BLANK_CYCLES=1, LAST_STEP=2 unless noted.
1. Reset then continuous scan: RST_N low then high, MODE=0, RUN=1.
   - Required: first cycle A=111 EN=0 SYNC=1, then 4 cycles EN=1 A=111.
   - Then 1 cycle A=110 EN=0, then 4 cycles EN=1, then A=101. Then wrap to A=111.
   - SYNC repeats every 15 cycles. DONE stays 0.
2. Single sweep: MODE=1, RUN=1, one START pulse.
   - Required: BUSY high for 15 cycles, steps A=111,110,101.
   - DONE=1 exactly one cycle after the last ACTIVE cycle. EN=0 and A=000 thereafter.
3. START ignored: a second START mid-sweep, and a START with RUN=0.
   - Required: sweep length unchanged (15 cycles), no extra DONE, no exit from IDLE when RUN=0.
4. RUN dropped during step 1 ACTIVE, cycle 2.
   - Required: next edge EN=0, A=000, BUSY=0, DONE=0.
   - RUN=1 again restarts at step 0 with SYNC.
5. Async reset mid-ACTIVE: pull RST_N low between clock edges.
   - Required: EN=0, A=000, BUSY=0 immediately, with no clock edge.
6. Parameters BLANK_CYCLES=0, LAST_STEP=7, MODE=0.
   - Required: EN held 1 continuously. A steps 111→000 every 4 cycles, then back to 111. SYNC every 32 cycles.

Source files
------------

// File: rtl/decoder_scan_driver.sv
// Purpose: sequences address/enable for a 3-to-8 active-low decoder; each step gets a blanking gap then a dwell.
// Latency: all outputs are registered and change one cycle after the qualifying run/mode/start edge.
// Backpressure: none; run=0 forces idle on the next edge, and start is ignored while busy.
module decoder_scan_driver #(
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 2,
    parameter int LAST_STEP    = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic mode,
    input  logic start,
    output logic en,
    output logic a0,
    output logic a1,
    output logic a2,
    output logic sync,
    output logic busy,
    output logic done
);

    // The counter only has to reach max(dwell, blank) - 1.
    localparam int CMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [2:0]    STEP_LAST  = 3'(LAST_STEP);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BLANK  = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    // With no blanking gap every step starts straight in its dwell.
    localparam state_t FIRST_ST = (BLANK_CYCLES > 0) ? S_BLANK : S_ACTIVE;

    state_t          state, state_n;
    logic [2:0]      step, step_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [2:0]      addr_q, addr_n;
    logic            en_n, sync_n, busy_n, done_n;

    assign {a2, a1, a0} = addr_q;

    // State, step, counter and all output registers; async reset clears them immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            step   <= 3'd0;
            cnt    <= '0;
            addr_q <= 3'd0;
            en     <= 1'b0;
            sync   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            step   <= step_n;
            cnt    <= cnt_n;
            addr_q <= addr_n;
            en     <= en_n;
            sync   <= sync_n;
            busy   <= busy_n;
            done   <= done_n;
        end
    end

    // Next-state logic; output values are derived from the next state so they register in step with it.
    always_comb begin
        state_n = state;
        step_n  = step;
        cnt_n   = cnt + CW'(1);
        sync_n  = 1'b0;
        done_n  = 1'b0;

        if (!run) begin
            state_n = S_IDLE;
            step_n  = 3'd0;
            cnt_n   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt_n = '0;
                    if (!mode || start) begin
                        state_n = FIRST_ST;
                        step_n  = 3'd0;
                        sync_n  = 1'b1;
                    end
                end
                S_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_n = S_ACTIVE;
                        cnt_n   = '0;
                    end
                end
                S_ACTIVE: begin
                    if (cnt == DWELL_LAST) begin
                        cnt_n = '0;
                        if (step != STEP_LAST) begin
                            step_n  = step + 3'd1;
                            state_n = FIRST_ST;
                        end else if (!mode) begin
                            // Continuous scan wraps; mode is re-sampled only here.
                            step_n  = 3'd0;
                            state_n = FIRST_ST;
                            sync_n  = 1'b1;
                        end else begin
                            // Single sweep finished; a coincident start is dropped.
                            step_n  = 3'd0;
                            state_n = S_IDLE;
                            done_n  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    step_n  = 3'd0;
                    cnt_n   = '0;
                end
            endcase
        end

        // Decoder selects DATA[k] when address is 7-k, i.e. the inverse of the step.
        en_n   = (state_n == S_ACTIVE);
        busy_n = (state_n != S_IDLE);
        addr_n = (state_n == S_IDLE) ? 3'd0 : ~step_n;
    end

endmodule

// File: tb/tb_decoder_scan_driver.sv
module tb_decoder_scan_driver;

    typedef struct packed {
        logic       en;
        logic [2:0] a;
        logic       sync;
        logic       busy;
        logic       done;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run = 1'b0, mode = 1'b0, start = 1'b0;
    logic en, a0, a1, a2, sync, busy, done;
    logic run6 = 1'b0, mode6 = 1'b0, start6 = 1'b0;
    logic en6, a06, a16, a26, sync6, busy6, done6;

    int total = 0;
    int bad = 0;

    obs_t  q1[$];
    string n1[$];
    obs_t  q6[$];
    string n6[$];

    localparam obs_t IDLE0 = '0;
    localparam obs_t DONE1 = 7'b0_000_001;

    always #5 clk = ~clk;

    decoder_scan_driver #(.DWELL_CYCLES(4), .BLANK_CYCLES(1), .LAST_STEP(2)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .mode(mode), .start(start),
        .en(en), .a0(a0), .a1(a1), .a2(a2), .sync(sync), .busy(busy), .done(done)
    );

    decoder_scan_driver #(.DWELL_CYCLES(4), .BLANK_CYCLES(0), .LAST_STEP(7)) dut6 (
        .clk(clk), .rst_n(rst_n), .run(run6), .mode(mode6), .start(start6),
        .en(en6), .a0(a06), .a1(a16), .a2(a26), .sync(sync6), .busy(busy6), .done(done6)
    );

    task automatic chk(input string nm, input obs_t act, input obs_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got en=%b a=%b sync=%b busy=%b done=%b, want en=%b a=%b sync=%b busy=%b done=%b",
                     nm, act.en, act.a, act.sync, act.busy, act.done,
                     exp.en, exp.a, exp.sync, exp.busy, exp.done);
        end
    endtask

    // Monitor: every cycle the DUTs present a fresh output vector; compare against the queued expectation.
    always @(negedge clk) begin
        obs_t e;
        string nm;
        if (q1.size() > 0) begin
            e  = q1.pop_front();
            nm = n1.pop_front();
            chk(nm, {en, a2, a1, a0, sync, busy, done}, e);
        end
        if (q6.size() > 0) begin
            e  = q6.pop_front();
            nm = n6.pop_front();
            chk(nm, {en6, a26, a16, a06, sync6, busy6, done6}, e);
        end
    end

    // Advance one edge on the main DUT and record what it must show afterwards; start is a one-edge pulse.
    task automatic cyc(input string nm, input obs_t e);
        @(posedge clk);
        #1;
        start = 1'b0;
        q1.push_back(e);
        n1.push_back(nm);
    endtask

    task automatic cyc6(input string nm, input obs_t e);
        @(posedge clk);
        #1;
        q6.push_back(e);
        n6.push_back(nm);
    endtask

    // First n cycles of a sweep (blank 1 + dwell 4 per step, steps 0..2); optional start pulse at index pulse_at.
    task automatic sweep(input string nm, input int n, input int pulse_at);
        for (int i = 0; i < n; i++) begin
            logic [2:0] s;
            obs_t e;
            int ph;
            s  = 3'(i / 5);
            ph = i % 5;
            e.en   = (ph != 0);
            e.a    = ~s;
            e.sync = (i == 0);
            e.busy = 1'b1;
            e.done = 1'b0;
            if (i == pulse_at) start = 1'b1;
            cyc(nm, e);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state, before any clock edge.
        #3;
        chk("reset main", {en, a2, a1, a0, sync, busy, done}, IDLE0);
        chk("reset dut6", {en6, a26, a16, a06, sync6, busy6, done6}, IDLE0);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // 1: continuous scan, two full periods to see the wrap and SYNC repeat.
        mode = 1'b0;
        run  = 1'b1;
        sweep("t1 scan0", 15, -1);
        sweep("t1 scan1", 15, -1);

        // 2: single sweep.
        run = 1'b0;
        cyc("t2 run off", IDLE0);
        mode = 1'b1;
        run  = 1'b1;
        cyc("t2 wait start", IDLE0);
        start = 1'b1;
        sweep("t2 sweep", 15, -1);
        cyc("t2 done", DONE1);
        cyc("t2 idle", IDLE0);

        // 3: start mid-sweep, start coincident with the end, start with run low.
        start = 1'b1;
        sweep("t3 sweep", 15, 7);
        start = 1'b1;
        cyc("t3 done collide", DONE1);
        cyc("t3 no restart", IDLE0);
        run   = 1'b0;
        start = 1'b1;
        cyc("t3 run0 start", IDLE0);
        cyc("t3 run0 idle", IDLE0);

        // 4: drop run during step 1 dwell cycle 2, then restart.
        mode = 1'b0;
        run  = 1'b1;
        sweep("t4 partial", 8, -1);
        run = 1'b0;
        cyc("t4 run drop", IDLE0);
        run = 1'b1;
        sweep("t4 restart", 15, -1);

        // 5: async reset in the middle of a dwell.
        sweep("t5 wrap", 3, -1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5 async reset", {en, a2, a1, a0, sync, busy, done}, IDLE0);
        run = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        cyc("t5 after reset", IDLE0);

        // 6: no blanking, eight steps, continuous.
        mode6 = 1'b0;
        run6  = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int s = 0; s < 8; s++) begin
                for (int c = 0; c < 4; c++) begin
                    obs_t e;
                    logic [2:0] sv;
                    sv = 3'(s);
                    e.en   = 1'b1;
                    e.a    = ~sv;
                    e.sync = (s == 0) && (c == 0);
                    e.busy = 1'b1;
                    e.done = 1'b0;
                    cyc6("t6 scan", e);
                end
            end
        end
        cyc6("t6 third sync", 7'b1_111_110);
        run6 = 1'b0;
        cyc6("t6 stop", IDLE0);

        @(negedge clk);
        @(negedge clk);
        if (q1.size() != 0 || q6.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d/%0d expectations left, want 0/0", q1.size(), q6.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
